// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample feeder: FSM states,
// default sample width, debug counter width and a saturating increment.
package audio_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } feed_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo pairs with registered full/empty/level flags.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2 * DATA_W_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_q;
    assign do_pop_s  = pop && !empty_q;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (do_push_s && !do_pop_s) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!do_push_s && do_pop_s) begin
            level_d = level_q - (AW+1)'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Pointers and flags; flags are registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
            empty_q <= (level_d == {(AW+1){1'b0}});
        end
    end

    // Storage array, write port only.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;
endmodule

// File: rtl/audio_sample_feeder.sv
// Paces stereo pairs from a FIFO into the DAC serial writer at a fixed
// sample rate, counting underruns and late ticks for debug.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DIV    = 1024,
    parameter int DATA_W = DATA_W_DEF,
    localparam int LW    = $clog2(DEPTH) + 1,
    localparam int DW    = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              dac_ready,
    output logic              dac_start,
    output logic [DATA_W-1:0] dac_data_a,
    output logic [DATA_W-1:0] dac_data_b,
    output logic [LW-1:0]     fifo_level,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  late_cnt
);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    feed_state_e             state_q;
    logic [DW-1:0]           div_cnt_q;
    logic [DW-1:0]           div_cnt_d;
    logic                    start_q;
    logic [DATA_W-1:0]       data_a_q;
    logic [DATA_W-1:0]       data_b_q;
    logic [CNT_W-1:0]        underrun_q;
    logic [CNT_W-1:0]        late_q;
    logic                    tick_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    serve_s;
    logic                    late_s;
    logic [2*DATA_W-1:0]     fifo_rdata_s;

    assign tick_s  = enable && (div_cnt_q == DIV_LAST);
    assign serve_s = tick_s && (state_q == ST_IDLE) && dac_ready;
    assign pop_s   = serve_s && !fifo_empty_s;
    assign late_s  = tick_s && !serve_s;
    assign push_s  = in_valid && !fifo_full_s;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata ({in_left, in_right}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Sample-rate divider; held at zero while disabled.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!enable) begin
            div_cnt_d = {DW{1'b0}};
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = {DW{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    // Writer handshake FSM with registered start/data and debug counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= {DW{1'b0}};
            start_q    <= 1'b0;
            data_a_q   <= {DATA_W{1'b0}};
            data_b_q   <= {DATA_W{1'b0}};
            underrun_q <= {CNT_W{1'b0}};
            late_q     <= {CNT_W{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
            if (late_s) late_q <= sat_inc(late_q);
            case (state_q)
                ST_IDLE: begin
                    if (serve_s) begin
                        if (fifo_empty_s) begin
                            // Empty at tick: resend the held pair.
                            underrun_q <= sat_inc(underrun_q);
                        end else begin
                            data_a_q <= fifo_rdata_s[2*DATA_W-1:DATA_W];
                            data_b_q <= fifo_rdata_s[DATA_W-1:0];
                        end
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (!dac_ready) begin
                        start_q <= 1'b0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dac_ready) state_q <= ST_IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = !fifo_full_s;
    assign dac_start    = start_q;
    assign dac_data_a   = data_a_q;
    assign dac_data_b   = data_b_q;
    assign underrun_cnt = underrun_q;
    assign late_cnt     = late_q;
endmodule

// File: tb/tb_audio_sample_feeder.sv
// Scoreboard bench: expected writer frames are queued as stimulus is issued
// and a monitor compares them on every rising dac_start.
module tb_audio_sample_feeder;
    localparam int DEPTH  = 4;
    localparam int DIV    = 8;
    localparam int DATA_W = 16;
    localparam int LW     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              dac_ready;
    logic              dac_start;
    logic [DATA_W-1:0] dac_data_a;
    logic [DATA_W-1:0] dac_data_b;
    logic [LW-1:0]     fifo_level;
    logic [7:0]        underrun_cnt;
    logic [7:0]        late_cnt;

    logic              wr_force_low;
    logic [31:0]       exp_q [$];
    int                checks = 0;
    int                errors = 0;

    audio_sample_feeder #(
        .DEPTH  (DEPTH),
        .DIV    (DIV),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .dac_ready    (dac_ready),
        .dac_start    (dac_start),
        .dac_data_a   (dac_data_a),
        .dac_data_b   (dac_data_b),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .late_cnt     (late_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Writer model: ready drops 2 cycles after start is seen, returns 20 cycles later.
    initial begin
        int wr_timer;
        wr_timer  = 0;
        dac_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (wr_force_low) begin
                dac_ready = 1'b0;
            end else if (wr_timer == 0) begin
                dac_ready = 1'b1;
                if (dac_start) wr_timer = 22;
            end else begin
                wr_timer  = wr_timer - 1;
                dac_ready = (wr_timer > 20) || (wr_timer == 0);
            end
        end
    end

    // Monitor: every new frame start must match the head of the queue.
    initial begin
        logic        prev;
        logic [31:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_start && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: actual %h_%h required none", dac_data_a, dac_data_b);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", {dac_data_a, dac_data_b}, e);
                end
            end
            prev = dac_start;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r, input bit exp_rdy);
        check("in_ready_before_push", in_ready, exp_rdy);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        if (exp_rdy) exp_q.push_back({l, r});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        logic prev;
        bit   seen;
        prev = dac_start;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (dac_start && !prev) seen = 1'b1;
            prev = dac_start;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: actual no start required start", name);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        in_valid     = 1'b0;
        in_left      = 16'h0000;
        in_right     = 16'h0000;
        wr_force_low = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_dac_start", dac_start, 0);
        check("rst_data_a", dac_data_a, 16'h0000);
        check("rst_data_b", dac_data_b, 16'h0000);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_late", late_cnt, 0);

        // Single transfer, then underrun resend of the last pair
        push_pair(16'habcd, 16'h1234, 1'b1);
        push_pair(16'hfa5f, 16'h0000, 1'b1);
        check("level_two", fifo_level, 2);
        enable = 1'b1;
        wait_start("first_start");
        check("level_after_first", fifo_level, 1);
        wait_start("second_start");
        check("level_after_second", fifo_level, 0);
        check("no_underrun_yet", underrun_cnt, 0);
        exp_q.push_back({16'hfa5f, 16'h0000});
        wait_start("underrun_start");
        check("underrun_one", underrun_cnt, 1);
        check("level_underrun", fifo_level, 0);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // Full: five offers with the divider stopped
        do_reset();
        check("full_rst_underrun", underrun_cnt, 0);
        check("full_rst_late", late_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            push_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i), i < 4);
        end
        check("full_in_ready", in_ready, 0);
        check("full_level", fifo_level, 4);
        @(negedge clk);
        check("full_level_hold", fifo_level, 4);

        // Late: writer busy across the first tick
        wr_force_low = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        check("late_one", late_cnt, 1);
        check("late_level", fifo_level, 4);
        check("late_no_start", dac_start, 0);
        check("late_no_underrun", underrun_cnt, 0);
        wr_force_low = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while in START
        enable = 1'b1;
        wait_start("midstart_start");
        check("midstart_level", fifo_level, 3);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("midstart_dac_start", dac_start, 0);
        check("midstart_level_rst", fifo_level, 0);
        check("midstart_underrun", underrun_cnt, 0);
        check("midstart_late", late_cnt, 0);
        check("midstart_in_ready", in_ready, 1);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
